// File: rtl/dec2chars12_1_1_32_1_pkg.sv
// Shared constants for the decimal-ASCII formatter.
//   - FSM state encoding (READY/CONV/STRIP)
//   - ASCII codes used to build the character bundle
//   - digit/character counts and a nibble-to-ASCII helper
package dec2chars12_1_1_32_1_pkg;

    localparam logic [1:0] ST_READY = 2'd0;
    localparam logic [1:0] ST_CONV  = 2'd1;
    localparam logic [1:0] ST_STRIP = 2'd2;

    localparam logic [7:0] ASCII_0   = 8'd48;
    localparam logic [7:0] ASCII_CR  = 8'd13;
    localparam logic [7:0] ASCII_LF  = 8'd10;
    localparam logic [7:0] CHAR_FILL = 8'd126;

    localparam int NDIGITS = 10;
    localparam int NCHARS  = 12;

    // Map one BCD nibble (0..9) to its ASCII digit.
    function automatic logic [7:0] digit_char(input logic [3:0] nib);
        return ASCII_0 + {4'd0, nib};
    endfunction

endpackage

// File: rtl/dec2chars12_1_1_32_1_dabble.sv
// dabble_adj10: combinational double-dabble adjust over ten BCD nibbles.
//   bcd_in  [39:0] : ten packed BCD nibbles
//   bcd_out [39:0] : same nibbles, each value >= 5 incremented by 3
module dabble_adj10 (
    input  logic [39:0] bcd_in,
    output logic [39:0] bcd_out
);

    // Per-nibble add-3 so the following left shift carries correctly into the next decade.
    always_comb begin
        bcd_out = bcd_in;
        for (int i = 0; i < 10; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5) begin
                bcd_out[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            end else begin
                bcd_out[4*i +: 4] = bcd_in[4*i +: 4];
            end
        end
    end

endmodule

// File: rtl/dec2chars12_1_1_32_1.sv
// dec2chars12_1_1_32_1: unsigned 32-bit binary to decimal ASCII formatter.
// Converts with iterative double-dabble (32 cycles), strips leading zeros
// one digit per cycle, then latches the character bundle and optional CR LF.
//   clk, reset     : clock, synchronous active-high reset
//   start          : one-cycle request, samples value/crlf, aborts any conversion
//   value [31:0]   : number to format
//   crlf           : append CR LF after the digits
//   n [3:0]        : valid character count (1..12), 0 after reset
//   c0..c11 [7:0]  : characters, c0 = most significant digit, unused = '~'
//   result         : bundle holds a completed conversion
//   result_ready   : idle and not being started this cycle
module dec2chars12_1_1_32_1
    import dec2chars12_1_1_32_1_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    input  logic        crlf,
    output logic [3:0]  n,
    output logic [7:0]  c0,
    output logic [7:0]  c1,
    output logic [7:0]  c2,
    output logic [7:0]  c3,
    output logic [7:0]  c4,
    output logic [7:0]  c5,
    output logic [7:0]  c6,
    output logic [7:0]  c7,
    output logic [7:0]  c8,
    output logic [7:0]  c9,
    output logic [7:0]  c10,
    output logic [7:0]  c11,
    output logic        result,
    output logic        result_ready
);

    logic [1:0]  state_r;
    logic [31:0] bin_r;
    logic [39:0] bcd_r;
    logic [4:0]  step_r;
    logic [3:0]  ndig_r;
    logic        crlf_r;
    logic [3:0]  n_r;
    logic [7:0]  c_r [NCHARS];
    logic        result_r;

    logic [39:0] adj_s;
    logic [3:0]  dig_s [NCHARS];
    logic [7:0]  lat_c_s [NCHARS];
    logic [3:0]  lat_n_s;

    dabble_adj10 u_adj (
        .bcd_in  (bcd_r),
        .bcd_out (adj_s)
    );

    // Build the character bundle that STRIP latches once leading zeros are gone.
    always_comb begin
        for (int i = 0; i < NCHARS; i++) begin
            dig_s[i] = 4'd0;
        end
        for (int i = 0; i < NDIGITS; i++) begin
            dig_s[i] = bcd_r[39-4*i -: 4];
        end
        for (int i = 0; i < NCHARS; i++) begin
            if (5'(i) < {1'b0, ndig_r}) begin
                lat_c_s[i] = digit_char(dig_s[i]);
            end else if (crlf_r && (5'(i) == {1'b0, ndig_r})) begin
                lat_c_s[i] = ASCII_CR;
            end else if (crlf_r && (5'(i) == ({1'b0, ndig_r} + 5'd1))) begin
                lat_c_s[i] = ASCII_LF;
            end else begin
                lat_c_s[i] = CHAR_FILL;
            end
        end
        if (crlf_r) begin
            lat_n_s = ndig_r + 4'd2;
        end else begin
            lat_n_s = ndig_r;
        end
    end

    // Conversion FSM plus output bundle registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_READY;
            bin_r    <= 32'd0;
            bcd_r    <= 40'd0;
            step_r   <= 5'd0;
            ndig_r   <= 4'd10;
            crlf_r   <= 1'b0;
            n_r      <= 4'd0;
            result_r <= 1'b0;
            for (int i = 0; i < NCHARS; i++) begin
                c_r[i] <= CHAR_FILL;
            end
        end else if (start) begin
            state_r  <= ST_CONV;
            bin_r    <= value;
            bcd_r    <= 40'd0;
            step_r   <= 5'd0;
            ndig_r   <= 4'd10;
            crlf_r   <= crlf;
            result_r <= 1'b0;
        end else begin
            case (state_r)
                ST_READY: begin
                    state_r <= ST_READY;
                end
                ST_CONV: begin
                    // Adjusted BCD and binary shift left together as one 72-bit register.
                    bcd_r  <= {adj_s[38:0], bin_r[31]};
                    bin_r  <= {bin_r[30:0], 1'b0};
                    step_r <= step_r + 5'd1;
                    if (step_r == 5'd31) begin
                        state_r <= ST_STRIP;
                    end else begin
                        state_r <= ST_CONV;
                    end
                end
                ST_STRIP: begin
                    if ((bcd_r[39:36] == 4'd0) && (ndig_r > 4'd1)) begin
                        bcd_r  <= {bcd_r[35:0], 4'd0};
                        ndig_r <= ndig_r - 4'd1;
                    end else begin
                        n_r      <= lat_n_s;
                        result_r <= 1'b1;
                        for (int i = 0; i < NCHARS; i++) begin
                            c_r[i] <= lat_c_s[i];
                        end
                        state_r <= ST_READY;
                    end
                end
                default: begin
                    state_r <= ST_READY;
                end
            endcase
        end
    end

    assign result_ready = (state_r == ST_READY) & ~start;
    assign n      = n_r;
    assign result = result_r;
    assign c0  = c_r[0];
    assign c1  = c_r[1];
    assign c2  = c_r[2];
    assign c3  = c_r[3];
    assign c4  = c_r[4];
    assign c5  = c_r[5];
    assign c6  = c_r[6];
    assign c7  = c_r[7];
    assign c8  = c_r[8];
    assign c9  = c_r[9];
    assign c10 = c_r[10];
    assign c11 = c_r[11];

endmodule

// File: tb/tb_dec2chars12_1_1_32_1.sv
// Self-checking bench for dec2chars12_1_1_32_1: directed cases plus random
// values checked against a decimal-arithmetic reference model.
module tb_dec2chars12_1_1_32_1;

    logic        clk = 1'b0;
    logic        reset, start, crlf;
    logic [31:0] value;
    logic [3:0]  n;
    logic [7:0]  c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11;
    logic        result, result_ready;

    int tests = 0;
    int fails = 0;

    logic [7:0] got_c [12];
    assign got_c[0] = c0;   assign got_c[1] = c1;   assign got_c[2] = c2;
    assign got_c[3] = c3;   assign got_c[4] = c4;   assign got_c[5] = c5;
    assign got_c[6] = c6;   assign got_c[7] = c7;   assign got_c[8] = c8;
    assign got_c[9] = c9;   assign got_c[10] = c10; assign got_c[11] = c11;

    logic [99:0] got_bundle;
    assign got_bundle = {n, c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11};

    dec2chars12_1_1_32_1 dut (
        .clk(clk), .reset(reset), .start(start), .value(value), .crlf(crlf),
        .n(n), .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5),
        .c6(c6), .c7(c7), .c8(c8), .c9(c9), .c10(c10), .c11(c11),
        .result(result), .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits by repeated division, then CR LF and fill.
    task automatic model(input logic [31:0] v, input bit cr,
                         output logic [3:0] en, output logic [7:0] ec [12], output int lat);
        int d [10];
        int nd;
        logic [31:0] t;
        nd = 0;
        t = v;
        do begin
            d[nd] = int'(t % 32'd10);
            t = t / 32'd10;
            nd++;
        end while (t != 32'd0);
        for (int i = 0; i < 12; i++) ec[i] = 8'd126;
        for (int i = 0; i < nd; i++) ec[i] = 8'(48 + d[nd-1-i]);
        if (cr) begin
            ec[nd] = 8'd13;
            ec[nd+1] = 8'd10;
            en = 4'(nd + 2);
        end else begin
            en = 4'(nd);
        end
        lat = 34 + (10 - nd);
    endtask

    function automatic logic [99:0] pack(input logic [3:0] en, input logic [7:0] ec [12]);
        logic [99:0] p;
        p = {96'd0, en};
        for (int i = 0; i < 12; i++) p = {p[91:0], ec[i]};
        return p;
    endfunction

    // Pulse start for one edge; returns after that edge.
    task automatic do_start(input logic [31:0] v, input bit cr);
        @(negedge clk);
        value = v;
        crlf  = cr;
        start = 1'b1;
        #1;
        check("rr_low_on_start", 128'(result_ready), 128'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges (start edge = 1) until result_ready, bounded.
    task automatic wait_ready(output int cyc);
        cyc = 1;
        while (!result_ready && cyc < 80) begin
            @(posedge clk);
            cyc++;
            #1;
        end
    endtask

    task automatic run_case(input string tag, input logic [31:0] v, input bit cr);
        logic [3:0] en;
        logic [7:0] ec [12];
        int lat, cyc;
        model(v, cr, en, ec, lat);
        do_start(v, cr);
        check({tag, "_busy_result"}, 128'(result), 128'd0);
        wait_ready(cyc);
        check({tag, "_latency"}, 128'(cyc), 128'(lat));
        check({tag, "_result"}, 128'(result), 128'd1);
        check({tag, "_bundle"}, 128'(got_bundle), 128'(pack(en, ec)));
    endtask

    initial begin
        logic [3:0] en;
        logic [7:0] ec [12];
        int lat, cyc;
        logic [31:0] rv;
        reset = 1'b1; start = 1'b0; value = 32'd0; crlf = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_n", 128'(n), 128'd0);
        check("reset_result", 128'(result), 128'd0);
        check("reset_ready", 128'(result_ready), 128'd1);
        for (int i = 0; i < 12; i++) check("reset_fill", 128'(got_c[i]), 128'd126);

        run_case("zero", 32'd0, 1'b0);
        run_case("max_crlf", 32'hFFFF_FFFF, 1'b1);
        run_case("v1205", 32'd1205, 1'b0);
        run_case("v1e9", 32'd1000000000, 1'b0);
        run_case("v9_crlf", 32'd9, 1'b1);

        // Abort: only the second conversion may appear.
        model(32'd7, 1'b1, en, ec, lat);
        do_start(32'd1000000, 1'b0);
        repeat (10) @(posedge clk);
        do_start(32'd7, 1'b1);
        wait_ready(cyc);
        check("abort_latency", 128'(cyc), 128'(lat));
        check("abort_result", 128'(result), 128'd1);
        check("abort_bundle", 128'(got_bundle), 128'(pack(en, ec)));

        // Reset during CONV.
        do_start(32'd123456, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_conv_n", 128'(n), 128'd0);
        check("rst_conv_result", 128'(result), 128'd0);
        check("rst_conv_ready", 128'(result_ready), 128'd1);
        for (int i = 0; i < 12; i++) check("rst_conv_fill", 128'(got_c[i]), 128'd126);
        run_case("after_rst", 32'd123456, 1'b1);

        // Hold in READY for 80 cycles, then back-to-back conversion.
        model(32'd123456, 1'b1, en, ec, lat);
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            check("hold_bundle", 128'(got_bundle), 128'(pack(en, ec)));
            check("hold_ready", 128'({result, result_ready}), 128'd3);
        end
        run_case("b2b", 32'd80808, 1'b0);

        // Random values with random digit counts.
        for (int k = 0; k < 24; k++) begin
            rv = $urandom;
            case ($urandom_range(0, 3))
                0: rv = rv % 32'd10;
                1: rv = rv % 32'd100000;
                2: rv = rv % 32'd100000000;
                default: rv = rv;
            endcase
            run_case("rand", rv, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
